// File: rtl/wr_wave_pkg.sv
// Shared definitions for the write-wavefront controller.
//   - State encoding of the controller FSM (IDLE / RUN / FIN).
//   - step_w(): width of the step counter so that the last step
//     (N + WIDTH - 2, with N up to 2^ADDR_W) never overflows it.
package wr_wave_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_FIN  = S_FIN
  } state_e;

  function automatic int step_w(input int width, input int addr_w);
    return addr_w + $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/wr_wave_ctrl_if.sv
// Handshake / write-bus bundle between the control FSM, the wavefront
// controller and the column-banked output memory.
//   start, num_rows, base_addr, stall : job request and flow control
//   busy, done                        : job status back to the FSM
//   wr_en[WIDTH], wr_addr[WIDTH*ADDR_W]: per-bank write enable / address
// master = requesting FSM side, slave = wr_wave_ctrl.
interface wr_wave_ctrl_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 8
);

  logic                      start;
  logic [ADDR_W:0]           num_rows;
  logic [ADDR_W-1:0]         base_addr;
  logic                      stall;
  logic                      busy;
  logic                      done;
  logic [WIDTH-1:0]          wr_en;
  logic [WIDTH*ADDR_W-1:0]   wr_addr;

  modport master (
    output start, num_rows, base_addr, stall,
    input  busy, done, wr_en, wr_addr
  );

  modport slave (
    input  start, num_rows, base_addr, stall,
    output busy, done, wr_en, wr_addr
  );

endinterface

// File: rtl/wr_wave_lane.sv
// One bank lane of the write wavefront (purely combinational).
//   t    : current step
//   n    : rows in the job
//   base : first row address
//   col  : this lane's column index
//   en   : bank write enable, high for col <= t <= col+n-1
//   addr : (base + t - col) mod 2^ADDR_W when enabled, else 0
module wr_wave_lane
  import wr_wave_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int ADDR_W = 8,
  localparam int TW     = step_w(WIDTH, ADDR_W)
) (
  input  logic [TW-1:0]     t,
  input  logic [ADDR_W:0]   n,
  input  logic [ADDR_W-1:0] base,
  input  logic [TW-1:0]     col,
  output logic              en,
  output logic [ADDR_W-1:0] addr
);

  // One extra bit so col + n cannot wrap in the window compare.
  logic [TW:0] t_x;
  logic [TW:0] c_x;
  logic [TW:0] end_x;

  assign t_x   = {1'b0, t};
  assign c_x   = {1'b0, col};
  assign end_x = c_x + {{(TW-ADDR_W){1'b0}}, n};

  assign en = (t_x >= c_x) && (t_x < end_x);

  // Address arithmetic is modulo 2^ADDR_W, so only the low bits matter.
  assign addr = en ? (base + t[ADDR_W-1:0] - col[ADDR_W-1:0]) : '0;

endmodule

// File: rtl/wr_wave_ctrl.sv
// Write-wavefront controller: on an accepted start it sweeps a step
// counter t and emits the skewed per-bank write enables and addresses
// that store an N-row tile into WIDTH column banks.
//   clk, reset : clock, synchronous active-high reset
//   bus        : wr_wave_ctrl_if slave (start/num_rows/base_addr/stall in,
//                busy/done/wr_en/wr_addr out, all outputs registered)
module wr_wave_ctrl
  import wr_wave_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  wr_wave_ctrl_if.slave bus
);

  localparam int TW = step_w(WIDTH, ADDR_W);
  localparam logic [ADDR_W:0] N_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_e                  state_q, state_d;
  logic [TW-1:0]           t_q, t_d;
  logic [ADDR_W:0]         n_q, n_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [ADDR_W:0]         n_clamp;
  logic [TW-1:0]           last_t;

  logic [WIDTH-1:0]        lane_en;
  logic [WIDTH*ADDR_W-1:0] lane_addr;
  logic [WIDTH-1:0]        wr_en_d, wr_en_p1;
  logic [WIDTH*ADDR_W-1:0] wr_addr_d, wr_addr_p1;
  logic                    busy_p1, done_p1;

  // Any request above 2^ADDR_W has the top bit set and saturates.
  assign n_clamp = bus.num_rows[ADDR_W] ? N_MAX : bus.num_rows;
  assign last_t  = {{(TW-ADDR_W-1){1'b0}}, n_q} + TW'(WIDTH - 2);

  for (genvar c = 0; c < WIDTH; c++) begin : g_lane
    wr_wave_lane #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
    ) u_lane (
      .t    (t_q),
      .n    (n_q),
      .base (base_q),
      .col  (TW'(c)),
      .en   (lane_en[c]),
      .addr (lane_addr[c*ADDR_W +: ADDR_W])
    );
  end

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    n_d       = n_q;
    base_d    = base_q;
    wr_en_d   = '0;
    wr_addr_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          n_d     = n_clamp;
          base_d  = bus.base_addr;
          t_d     = '0;
          state_d = (n_clamp == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        // A stalled edge holds t and loads zeros into the outputs.
        if (!bus.stall) begin
          wr_en_d   = lane_en;
          wr_addr_d = lane_addr;
          t_d       = t_q + TW'(1);
          if (t_q == last_t) state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- stage p1: registered outputs and controller state ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      t_q        <= '0;
      n_q        <= '0;
      base_q     <= '0;
      wr_en_p1   <= '0;
      wr_addr_p1 <= '0;
      busy_p1    <= 1'b0;
      done_p1    <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      n_q        <= n_d;
      base_q     <= base_d;
      wr_en_p1   <= wr_en_d;
      wr_addr_p1 <= wr_addr_d;
      // busy drops on the same edge that raises done.
      busy_p1    <= (state_d != ST_IDLE);
      done_p1    <= (state_q == ST_FIN);
    end
  end

  assign bus.wr_en   = wr_en_p1;
  assign bus.wr_addr = wr_addr_p1;
  assign bus.busy    = busy_p1;
  assign bus.done    = done_p1;

endmodule
